// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
// A request is held (rd/addr stable) until the memory answers with done.
interface fetch_stage_if;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;

    modport master (output imem_rd, output imem_addr, input imem_rdata, input imem_done);
    modport slave  (input imem_rd, input imem_addr, output imem_rdata, output imem_done);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, buffers one instruction under stall,
// handles redirects and parks on HALT. Optional FETCH_ALIGN_CHECK_EN adds odd-PC detection (align_err).
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    fetch_stage_if.master mem,
    output logic [15:0]   instr_out,
    output logic [15:0]   nextPC_out,
    output logic          fetch_valid,
    output logic          halted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic          align_err
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic        buf_vld_q, buf_vld_d;
    logic        buf_halt_q, buf_halt_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_npc_q, buf_npc_d;
    logic        drop_q, drop_d;

    logic        accept;
    logic [15:0] acc_addr;
    logic [15:0] acc_npc;
    logic        acc_is_halt;
    logic        aerr;

    assign acc_npc     = acc_addr + 16'd2;
    assign acc_is_halt = (mem.imem_rdata[15:11] == HALT_OPCODE);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_vld_d   = buf_vld_q;
        buf_halt_d  = buf_halt_q;
        buf_instr_d = buf_instr_q;
        buf_npc_d   = buf_npc_q;
        drop_d      = drop_q;
        accept      = 1'b0;
        acc_addr    = req_addr_q;
        aerr        = 1'b0;
        mem.imem_rd   = 1'b0;
        mem.imem_addr = pc_q;
        fetch_valid = 1'b0;
        instr_out   = NOP_INSTR;
        nextPC_out  = 16'h0000;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (buf_vld_q) begin
                    // Replay the buffered instruction until decode takes it.
                    if (!redirect) begin
                        fetch_valid = 1'b1;
                        instr_out   = buf_instr_q;
                        nextPC_out  = buf_npc_q;
                        if (!stall) begin
                            buf_vld_d = 1'b0;
                            if (buf_halt_q) state_d = S_HALT;
                        end
                    end
                end else if (!redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_q[0]) begin
                        aerr        = 1'b1;
                        fetch_valid = 1'b1;
                        nextPC_out  = pc_q + 16'd2;
                        state_d     = S_HALT;
                    end else
`endif
                    begin
                        mem.imem_rd   = 1'b1;
                        mem.imem_addr = pc_q;
                        req_addr_d    = pc_q;
                        if (mem.imem_done) begin
                            accept   = 1'b1;
                            acc_addr = pc_q;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                // An issued read cannot be withdrawn; a pending redirect only marks its data for discard.
                mem.imem_rd   = 1'b1;
                mem.imem_addr = req_addr_q;
                if (mem.imem_done) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (!redirect) begin
                        accept   = 1'b1;
                        acc_addr = req_addr_q;
                    end
                end
            end
            S_HALT: begin
                halted = !redirect;
            end
            default: state_d = S_FETCH;
        endcase

        if (accept) begin
            fetch_valid = 1'b1;
            instr_out   = mem.imem_rdata;
            nextPC_out  = acc_npc;
            pc_d        = acc_npc;
            if (stall) begin
                buf_vld_d   = 1'b1;
                buf_halt_d  = acc_is_halt;
                buf_instr_d = mem.imem_rdata;
                buf_npc_d   = acc_npc;
                state_d     = S_FETCH;
            end else begin
                state_d = acc_is_halt ? S_HALT : S_FETCH;
            end
        end

        if (redirect) begin
            pc_d       = redirect_pc;
            buf_vld_d  = 1'b0;
            buf_halt_d = 1'b0;
            if (state_q == S_WAIT && !mem.imem_done) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = S_FETCH;
            end
        end

        if (rst) begin
            mem.imem_rd = 1'b0;
            fetch_valid = 1'b0;
            instr_out   = NOP_INSTR;
            nextPC_out  = 16'h0000;
            halted      = 1'b0;
            aerr        = 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_err = aerr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            buf_vld_q  <= 1'b0;
            buf_halt_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_vld_q  <= buf_vld_d;
            buf_halt_q <= buf_halt_d;
            drop_q     <= drop_d;
        end
    end

    // Data-only registers: meaningful only when their valid/state qualifiers say so.
    always_ff @(posedge clk) begin
        req_addr_q  <= req_addr_d;
        buf_instr_q <= buf_instr_d;
        buf_npc_q   <= buf_npc_d;
    end

endmodule
